fifo_ram_sym: RTL and testbench

Synchronous single-clock FIFO built on an internal register-file RAM, with a usable depth (ADDR_AVALABLE) that need not be a power of two. The default configuration is 13 entries of 8 bits. It sits between a producer and a consumer in the same clock domain and reports full/empty status. Writes are ignored while full and reads are ignored while empty.

---
 rtl/fifo_ram_sym.sv | 42 ++++
 tb/tb_fifo_ram_sym.sv | 86 ++++++++
 2 files changed

// File: rtl/fifo_ram_sym.sv
// fifo_ram_sym: single-clock register-file FIFO with non-power-of-two depth, registered read data and full/empty flags
module fifo_ram_sym #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ADDR_AVALABLE = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r_en,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full
);
  logic [DATA_WIDTH-1:0] mem [ADDR_AVALABLE];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [ADDR_WIDTH:0]   cnt;
  logic                  wa, ra;
  assign empty  = cnt == '0;
  assign full   = cnt == (ADDR_WIDTH+1)'(ADDR_AVALABLE);
  assign ra     = r_en && !empty;
  assign wa     = w_en && (!full || r_en);
  assign wr_nxt = wr_ptr == ADDR_WIDTH'(ADDR_AVALABLE-1) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt = rd_ptr == ADDR_WIDTH'(ADDR_AVALABLE-1) ? '0 : rd_ptr + 1'b1;
  always_ff @(posedge clk)
    if (wa) mem[wr_ptr] <= w_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      r_data <= '0;
    end else begin
      if (wa) wr_ptr <= wr_nxt;
      if (ra) begin
        rd_ptr <= rd_nxt;
        r_data <= mem[rd_ptr];
      end
      cnt <= wa && !ra ? cnt + 1'b1 : ra && !wa ? cnt - 1'b1 : cnt;
    end
endmodule

// File: tb/tb_fifo_ram_sym.sv
// tb_fifo_ram_sym: directed plus randomized checks of fifo_ram_sym against a queue model
module tb_fifo_ram_sym;
  localparam int DEPTH = 13;
  logic       clk = 0, reset = 0, r_en = 0, w_en = 0;
  logic [7:0] w_data = 0, r_data;
  logic       empty, full;
  logic [7:0] q[$];
  logic [7:0] exp_r = 0;
  int         n_cmp = 0, n_err = 0;
  fifo_ram_sym dut (
    .clk(clk), .reset(reset), .r_en(r_en), .w_en(w_en),
    .w_data(w_data), .r_data(r_data), .empty(empty), .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".r_data"}, 32'(r_data), 32'(exp_r));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
  endtask
  task automatic step(input string tag, input logic r, input logic w, input logic [7:0] d);
    logic ra, wa;
    r_en = r; w_en = w; w_data = d;
    ra = r && q.size() != 0;
    wa = w && (q.size() != DEPTH || r);
    @(posedge clk); #1;
    if (ra) exp_r = q.pop_front();
    if (wa) q.push_back(d);
    chk_all(tag);
  endtask
  task automatic do_reset(input string tag);
    r_en = 0; w_en = 0;
    reset = 0;
    #1;
    q.delete();
    exp_r = 0;
    chk_all(tag);
    @(posedge clk); #1;
    reset = 1;
  endtask
  initial begin
    #3;
    chk_all("por");
    @(posedge clk); #1;
    reset = 1;
    for (int i = 0; i < 5; i++) step("pre", 1'b0, 1'b1, 8'(8'hE0 + i));
    step("pre_rd", 1'b1, 1'b0, 8'h00);
    do_reset("mid_reset");
    step("rd_after_reset", 1'b1, 1'b0, 8'h00);
    chk("rd_after_reset.zero", 32'(r_data), 32'h0);
    for (int i = 0; i < 20; i++) step("fill", 1'b0, 1'b1, 8'(8'h80 + i));
    chk("fill.cnt", q.size(), DEPTH);
    for (int i = 0; i < 15; i++) step("drain", 1'b1, 1'b0, 8'h00);
    chk("drain.hold_d12", 32'(r_data), 32'h8C);
    for (int i = 0; i < 10; i++) step("wrap_w10", 1'b0, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 10; i++) step("wrap_r10", 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 13; i++) step("wrap_w13", 1'b0, 1'b1, 8'(8'h30 + i));
    for (int i = 0; i < 13; i++) step("wrap_r13", 1'b1, 1'b0, 8'h00);
    chk("wrap.last", 32'(r_data), 32'h3C);
    for (int i = 0; i < 13; i++) step("sf_fill", 1'b0, 1'b1, 8'(1 + i));
    step("sim_full", 1'b1, 1'b1, 8'hAA);
    chk("sim_full.r_data", 32'(r_data), 32'h01);
    chk("sim_full.full", 32'(full), 32'h1);
    for (int i = 0; i < 13; i++) step("sf_drain", 1'b1, 1'b0, 8'h00);
    chk("sf_drain.last", 32'(r_data), 32'hAA);
    step("sim_empty", 1'b1, 1'b1, 8'h55);
    chk("sim_empty.hold", 32'(r_data), 32'hAA);
    chk("sim_empty.empty", 32'(empty), 32'h0);
    step("sim_empty_rd", 1'b1, 1'b0, 8'h00);
    chk("sim_empty_rd.data", 32'(r_data), 32'h55);
    for (int i = 0; i < 800; i++) begin
      int wp;
      wp = (i / 100) % 2 == 0 ? 75 : 30;
      if (i == 400) do_reset("rand_reset");
      step("rand", 1'($urandom_range(0, 99) < 100 - wp), 1'($urandom_range(0, 99) < wp), 8'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
